// File: rtl/lcd_reader.sv
// HD44780 read-side controller: reads the busy flag/address counter, or one DDRAM
// byte after an internal Set-DDRAM-Address write, on the shared DE2-115 LCD bus.
module lcd_reader #(
  parameter int SETUP_CYC   = 2,
  parameter int ENABLE_CYC  = 2,
  parameter int PROC_CYC    = 500,
  parameter int RECOVER_CYC = 2
) (
  input  logic       i_clk_800k,
  input  logic       i_rst_n,
  inout  wire  [7:0] io_LCD_DATA,
  output logic       o_LCD_EN,
  output logic       o_LCD_RS,
  output logic       o_LCD_RW,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic [6:0] i_address,
  output logic       o_busy,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_bf,
  output logic [6:0] o_ac
);

  localparam int ADDR_LEN = SETUP_CYC + ENABLE_CYC + PROC_CYC;
  localparam int READ_LEN = SETUP_CYC + ENABLE_CYC + RECOVER_CYC;
  localparam int MAX_LEN  = (ADDR_LEN > READ_LEN) ? ADDR_LEN : READ_LEN;
  localparam int CNT_W    = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_LEN - 1);
  localparam logic [CNT_W-1:0] EN_FIRST  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] EN_END    = CNT_W'(SETUP_CYC + ENABLE_CYC);
  localparam logic [CNT_W-1:0] CAP_CNT   = CNT_W'(SETUP_CYC + ENABLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, ADDR_WR, READ, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mode_q, mode_n;
  logic [6:0]       addr_q, addr_n;
  logic             drive_q;
  logic             in_phase, en_n, rs_n, rw_n, drive_n, busy_n, valid_n;

  // The bus carries the Set-DDRAM-Address instruction only while drive_q is set
  assign io_LCD_DATA = drive_q ? {1'b1, addr_q} : 8'bz;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_q;
    addr_n  = addr_q;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
        if (i_start) begin
          mode_n  = i_mode;
          addr_n  = i_address;
          state_n = i_mode ? ADDR_WR : READ;
        end
      end
      ADDR_WR: begin
        if (cnt == ADDR_LAST) begin
          state_n = READ;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      READ: begin
        if (cnt == READ_LAST) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are decoded from the upcoming state so the registered pins line up with it
    in_phase = (state_n == ADDR_WR) || (state_n == READ);
    en_n     = in_phase && (cnt_n >= EN_FIRST) && (cnt_n < EN_END);
    rs_n     = (state_n == READ) && mode_n;
    rw_n     = (state_n != ADDR_WR);
    drive_n  = (state_n == ADDR_WR);
    busy_n   = in_phase;
    valid_n  = (state_n == DONE);
  end

  always_ff @(posedge i_clk_800k) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      drive_q  <= 1'b0;
      o_LCD_EN <= 1'b0;
      o_LCD_RS <= 1'b0;
      o_LCD_RW <= 1'b1;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_bf     <= 1'b0;
      o_ac     <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      mode_q   <= mode_n;
      addr_q   <= addr_n;
      drive_q  <= drive_n;
      o_LCD_EN <= en_n;
      o_LCD_RS <= rs_n;
      o_LCD_RW <= rw_n;
      o_busy   <= busy_n;
      o_valid  <= valid_n;
      // Sample on the edge closing the final EN-high cycle, while the LCD still drives
      if (state == READ && cnt == CAP_CNT) begin
        o_data <= io_LCD_DATA;
        if (!mode_q) begin
          o_bf <= io_LCD_DATA[7];
          o_ac <= io_LCD_DATA[6:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: directed scenarios plus randomized operations
// compared cycle by cycle against a timeline model of each read operation.
`timescale 1ns/1ps
module tb_lcd_reader;

  localparam int S     = 2;
  localparam int E     = 2;
  localparam int P     = 500;
  localparam int R     = 2;
  localparam int A_LEN = S + E + P;
  localparam int L_LEN = S + E + R;

  logic       clk = 1'b0;
  logic       rst_n;
  tri1  [7:0] lcd_bus;
  logic       en, rs, rw;
  logic       start, mode;
  logic [6:0] address;
  logic       busy, valid;
  logic [7:0] data;
  logic       bf;
  logic [6:0] ac;

  logic [7:0] lcd_rdata;
  logic [7:0] exp_data;
  logic       exp_bf;
  logic [6:0] exp_ac;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // LCD panel model: drives its read data whenever a read strobe is active
  assign lcd_bus = (en && rw) ? lcd_rdata : 8'bz;

  lcd_reader #(
    .SETUP_CYC(S), .ENABLE_CYC(E), .PROC_CYC(P), .RECOVER_CYC(R)
  ) dut (
    .i_clk_800k(clk),
    .i_rst_n(rst_n),
    .io_LCD_DATA(lcd_bus),
    .o_LCD_EN(en),
    .o_LCD_RS(rs),
    .o_LCD_RW(rw),
    .i_start(start),
    .i_mode(mode),
    .i_address(address),
    .o_busy(busy),
    .o_valid(valid),
    .o_data(data),
    .o_bf(bf),
    .o_ac(ac)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, expv);
    end
  endtask

  task automatic checkAll(input logic e_en, input logic e_rs, input logic e_rw,
                          input logic [7:0] e_bus, input logic e_busy, input logic e_valid);
    checkOutput("en",    32'(en),      32'(e_en));
    checkOutput("rs",    32'(rs),      32'(e_rs));
    checkOutput("rw",    32'(rw),      32'(e_rw));
    checkOutput("bus",   32'(lcd_bus), 32'(e_bus));
    checkOutput("busy",  32'(busy),    32'(e_busy));
    checkOutput("valid", 32'(valid),   32'(e_valid));
    checkOutput("data",  32'(data),    32'(exp_data));
    checkOutput("bf",    32'(bf),      32'(exp_bf));
    checkOutput("ac",    32'(ac),      32'(exp_ac));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checkAll(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      start   = 1'b0;
      mode    = 1'($urandom);
      address = 7'($urandom);
    end
  endtask

  // Called in cycle 0 (DUT idle or in DONE); the op's timeline is derived from the
  // phase lengths. g1/g2 pulse i_start while busy, rst_at asserts reset in that
  // cycle, keep holds i_start high through DONE so another op can chain.
  task automatic applyStimulus(input logic m, input logic [6:0] adr, input logic [7:0] rd,
                               input int g1, input int g2, input int rst_at, input bit keep);
    int         rstart, vcyc, cap;
    logic       e_en, e_rs, e_rw;
    logic [7:0] e_bus;
    rstart    = m ? A_LEN + 1 : 1;
    vcyc      = rstart + L_LEN;
    cap       = rstart + S + E;
    lcd_rdata = rd;
    start     = 1'b1;
    mode      = m;
    address   = adr;
    for (int k = 1; k <= vcyc; k++) begin
      @(posedge clk); #1;
      if (k == cap) begin
        exp_data = rd;
        if (!m) begin
          exp_bf = rd[7];
          exp_ac = rd[6:0];
        end
      end
      e_en = (m && k >= S + 1 && k <= S + E) || (k >= rstart + S && k < rstart + S + E);
      e_rw = !(m && k <= A_LEN);
      e_rs = (k >= rstart && k < vcyc) ? m : 1'b0;
      if (!e_rw)     e_bus = {1'b1, adr};
      else if (e_en) e_bus = rd;
      else           e_bus = 8'hFF;
      checkAll(e_en, e_rs, e_rw, e_bus, k < vcyc, k == vcyc);
      if (k == rst_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        exp_data = 8'h00;
        exp_bf   = 1'b0;
        exp_ac   = 7'h00;
        checkAll(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        return;
      end
      start   = (k == g1) || (k == g2) || keep;
      mode    = 1'($urandom);
      address = 7'($urandom);
    end
  endtask

  initial begin
    int   v, g1, g2, rst_at;
    bit   keep;
    logic m;
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    address   = 7'h00;
    lcd_rdata = 8'h00;
    exp_data  = 8'h00;
    exp_bf    = 1'b0;
    exp_ac    = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    checkAll(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b1;
    idleCycles(20);

    applyStimulus(1'b0, 7'h00, 8'h85, -1, -1, -1, 1'b0);
    idleCycles(3);
    applyStimulus(1'b1, 7'h40, 8'h41, -1, -1, -1, 1'b0);
    idleCycles(3);
    applyStimulus(1'b1, 7'h15, 8'h3C, 3, 300, -1, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 7'h00, 8'h27, -1, -1, -1, 1'b1);
    applyStimulus(1'b0, 7'h00, 8'hA3, -1, -1, -1, 1'b0);
    idleCycles(3);
    applyStimulus(1'b1, 7'h2A, 8'h5E, -1, -1, 200, 1'b0);
    idleCycles(5);

    for (int i = 0; i < 12; i++) begin
      m      = 1'($urandom);
      v      = m ? A_LEN + 1 + L_LEN : 1 + L_LEN;
      g1     = int'($urandom_range(v - 2, 1));
      g2     = int'($urandom_range(v - 2, 1));
      rst_at = ($urandom_range(5, 0) == 0) ? int'($urandom_range(v - 1, 1)) : -1;
      keep   = (i != 11) && ($urandom_range(2, 0) == 0);
      applyStimulus(m, 7'($urandom), 8'($urandom), g1, g2, rst_at, keep);
      if (!keep) idleCycles(2);
    end
    idleCycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
